// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling 8N1 UART receiver (LSB first).
//
// The serial line is brought into the clock domain through a two-flop
// synchronizer. A prescaler produces one tick per sample slot (OVERSAMPLE
// slots per bit). The start bit is confirmed at its middle, and every later
// bit is sampled one full bit period after the previous sample.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit.
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   BAUD_RATE   line bit rate
//   OVERSAMPLE  sample ticks per bit (must fit the 4-bit sample counter)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   rxd         asynchronous serial input, idles high
//   data_out    last good byte, held until the next good frame
//   data_valid  one-cycle pulse, data_out carries a new byte
//   frame_err   one-cycle pulse, stop bit sampled low
//   parity_err  one-cycle pulse, parity mismatch (constant 0 without parity)
//   busy        high from an accepted start edge until the stop decision
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    SAMP_MID   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    SAMP_LAST  = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    state_e          state_q,      state_d;
    logic            sync1_q,      sync1_d;
    logic            sync2_q,      sync2_d;
    logic            rxd_prev_q,   rxd_prev_d;
    logic [PW-1:0]   presc_q,      presc_d;
    logic [3:0]      samp_cnt_q,   samp_cnt_d;
    logic [2:0]      bit_idx_q,    bit_idx_d;
    logic [7:0]      shreg_q,      shreg_d;
    logic [7:0]      data_out_q,   data_out_d;
    logic            data_valid_q, data_valid_d;
    logic            frame_err_q,  frame_err_d;
    logic            busy_q,       busy_d;
`ifdef UART_RX_PARITY_EN
    logic            parity_bit_q, parity_bit_d;
    logic            parity_err_q, parity_err_d;
`endif

    logic rxd_s;
    logic tick;

    assign rxd_s = sync2_q;
    assign tick  = (presc_q == PRESC_LAST);

    always_comb begin
        // NOTE: every _d signal gets a default before the case statement so
        // no path leaves it unassigned and no latch is inferred.
        sync1_d      = rxd;
        sync2_d      = sync1_q;
        rxd_prev_d   = rxd_s;
        state_d      = state_q;
        samp_cnt_d   = samp_cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        busy_d       = busy_q;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
        parity_err_d = 1'b0;
`endif

        // Prescaler is parked at zero while idle so the first tick of a frame
        // lands a fixed distance after the detected start edge.
        if (state_q == ST_IDLE || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                samp_cnt_d = '0;
                bit_idx_d  = '0;
                busy_d     = 1'b0;
                // Only a genuine 1->0 transition arms a frame; a line stuck
                // low (break) never re-triggers.
                if (rxd_prev_q && !rxd_s) begin
                    state_d = ST_START;
                    busy_d  = 1'b1;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (samp_cnt_q == SAMP_MID) begin
                        if (rxd_s) begin
                            // Line went back high before mid-bit: glitch.
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d    = ST_DATA;
                            samp_cnt_d = '0;
                            bit_idx_d  = '0;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 4'd1;
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (samp_cnt_q == SAMP_LAST) begin
                        samp_cnt_d         = '0;
                        shreg_d[bit_idx_q] = rxd_s;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d   = ST_PARITY;
`else
                            state_d   = ST_STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 4'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (samp_cnt_q == SAMP_LAST) begin
                        samp_cnt_d   = '0;
                        parity_bit_d = rxd_s;
                        state_d      = ST_STOP;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 4'd1;
                    end
                end
            end
`endif

            ST_STOP: begin
                if (tick) begin
                    if (samp_cnt_q == SAMP_LAST) begin
                        samp_cnt_d = '0;
                        state_d    = ST_IDLE;
                        busy_d     = 1'b0;
                        if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
                            // Even parity: data plus parity bit hold an even
                            // number of ones.
                            if (^{shreg_q, parity_bit_q}) begin
                                parity_err_d = 1'b1;
                            end else begin
                                data_out_d   = shreg_q;
                                data_valid_d = 1'b1;
                            end
`else
                            data_out_d   = shreg_q;
                            data_valid_d = 1'b1;
`endif
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 4'd1;
                    end
                end
            end

            default: begin
                // Unused encodings (including PARITY when it is not built).
                state_d    = ST_IDLE;
                samp_cnt_d = '0;
                bit_idx_d  = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the synchronizer resets to 1, the idle line level, so
            // leaving reset while rxd is low is never taken as a start edge.
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rxd_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            samp_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples the values from before this edge.
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            rxd_prev_q   <= rxd_prev_d;
            state_q      <= state_d;
            presc_q      <= presc_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= parity_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at default parameters
// (27 clk per tick, 432 clk per bit). Expected pulses are queued when a frame
// is driven and matched against the DUT outputs by a monitor on the falling
// clock edge. Define UART_RX_PARITY_EN for both files to exercise parity.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT_CLK  = 432;
    localparam int TICK_DIV = 27;
    localparam int CLK_PER  = 10;
    // Start edge to data_valid: 9.5 bits + 2 sync cycles + 1 register cycle.
    localparam int LATENCY  = 4107;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd   = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #(CLK_PER / 2) clk = ~clk;

    typedef enum logic [1:0] {EV_VALID, EV_FRAME, EV_PARITY} ev_kind_e;
    typedef struct packed {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_got;
    ev_t        mon_exp;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_good = 8'h00;
    time        last_valid_time = 0;

    // Scoreboard monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (data_valid || frame_err || parity_err)) begin
            checks++;
            if ($countones({data_valid, frame_err, parity_err}) > 1) begin
                errors++;
                $display("FAIL pulse_exclusive got valid=%b frame=%b parity=%b required at most one",
                         data_valid, frame_err, parity_err);
            end
            mon_got.kind = data_valid ? EV_VALID : (frame_err ? EV_FRAME : EV_PARITY);
            mon_got.data = data_valid ? data_out : 8'h00;
            if (data_valid) last_valid_time = $time;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got kind=%0d data=%h required no pulse",
                         mon_got.kind, mon_got.data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL pulse_match got kind=%0d data=%h required kind=%0d data=%h",
                             mon_got.kind, mon_got.data, mon_exp.kind, mon_exp.data);
                end
            end
        end
    end

    initial begin
        #(CLK_PER * 100000);
        $display("FAIL watchdog simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // par_v is the parity bit to send when parity is compiled in.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_v, BIT_CLK);
`endif
        drive_bit(stop_v, BIT_CLK);
    endtask

    task automatic expect_valid(input logic [7:0] d);
        exp_q.push_back('{kind: EV_VALID, data: d});
        last_good = d;
    endtask

    task automatic expect_kind(input ev_kind_e k);
        exp_q.push_back('{kind: k, data: 8'h00});
    endtask

    task automatic send_good(input logic [7:0] d);
        expect_valid(d);
        send_frame(d, 1'b1, ^d);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2 * BIT_CLK) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending got=%0d events required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxd   = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_out got=%h required=00", data_out);
        end
        checks++;
        if ({data_valid, frame_err, parity_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses got=%b required=000", {data_valid, frame_err, parity_err});
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b required=0", busy);
        end
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_bit(1'b1, 50);
    endtask

    task automatic test_basic();
        time t_start;
        t_start = $time;
        send_good(8'hA5);
        wait_drain("basic_a5");
        checks++;
        if (data_out !== 8'hA5) begin
            errors++;
            $display("FAIL basic_data got=%h required=a5", data_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_after got=%b required=0", busy);
        end
        checks++;
        if ((last_valid_time - t_start) / CLK_PER != LATENCY) begin
            errors++;
            $display("FAIL basic_latency got=%0d required=%0d cycles",
                     (last_valid_time - t_start) / CLK_PER, LATENCY);
        end
        drive_bit(1'b1, 100);
    endtask

    task automatic test_back_to_back();
        send_good(8'h00);
        send_good(8'hFF);
        wait_drain("back_to_back");
        checks++;
        if (data_out !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_data got=%h required=ff", data_out);
        end
        drive_bit(1'b1, 100);
    endtask

    task automatic test_glitch();
        int n;
        drive_bit(1'b0, 100);
        rxd = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_rise got=%b required=1", busy);
        end
        n = 100;
        while (busy && n < 216 + TICK_DIV) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_fall got=%b after %0d clk required=0", busy, n);
        end
        drive_bit(1'b1, BIT_CLK * 2);
        wait_drain("glitch");
        checks++;
        if (data_out !== last_good) begin
            errors++;
            $display("FAIL glitch_data got=%h required=%h", data_out, last_good);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] prev;
        prev = last_good;
        expect_kind(EV_FRAME);
        send_frame(8'h3C, 1'b0, ^8'h3C);
        drive_bit(1'b1, 100);
        wait_drain("frame_err");
        checks++;
        if (data_out !== prev) begin
            errors++;
            $display("FAIL frame_err_hold got=%h required=%h", data_out, prev);
        end
        send_good(8'h12);
        wait_drain("after_frame_err");
        checks++;
        if (data_out !== 8'h12) begin
            errors++;
            $display("FAIL after_frame_err_data got=%h required=12", data_out);
        end
        drive_bit(1'b1, 100);
    endtask

    task automatic test_break();
        expect_kind(EV_FRAME);
        send_frame(8'h81, 1'b0, ^8'h81);
        drive_bit(1'b0, BIT_CLK * 10);
        drive_bit(1'b1, 200);
        wait_drain("break");
        send_good(8'h6E);
        wait_drain("after_break");
        checks++;
        if (data_out !== 8'h6E) begin
            errors++;
            $display("FAIL after_break_data got=%h required=6e", data_out);
        end
        drive_bit(1'b1, 100);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h55;
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLK);
        drive_bit(d[4], 200);
        rst_n = 1'b0;
        drive_bit(d[4], BIT_CLK - 200);
        checks++;
        if ({data_out, data_valid, frame_err, parity_err, busy} !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset_outputs got data=%h v=%b f=%b p=%b busy=%b required all zero",
                     data_out, data_valid, frame_err, parity_err, busy);
        end
        for (int i = 5; i < 8; i++) drive_bit(d[i], BIT_CLK);
        drive_bit(1'b1, BIT_CLK);
        last_good = 8'h00;
        rst_n = 1'b1;
        drive_bit(1'b1, 100);
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_no_partial got=%h required=00", data_out);
        end
        send_good(8'h55);
        wait_drain("after_mid_reset");
        checks++;
        if (data_out !== 8'h55) begin
            errors++;
            $display("FAIL after_mid_reset_data got=%h required=55", data_out);
        end
        drive_bit(1'b1, 100);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [7:0] prev;
        prev = last_good;
        expect_kind(EV_PARITY);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_drain("parity_bad");
        checks++;
        if (data_out !== prev) begin
            errors++;
            $display("FAIL parity_bad_hold got=%h required=%h", data_out, prev);
        end
        expect_kind(EV_FRAME);
        send_frame(8'h07, 1'b0, 1'b0);
        drive_bit(1'b1, 100);
        wait_drain("parity_and_stop_bad");
        expect_valid(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_drain("parity_good");
        checks++;
        if (data_out !== 8'h07) begin
            errors++;
            $display("FAIL parity_good_data got=%h required=07", data_out);
        end
        drive_bit(1'b1, 100);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_break();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit; localparam TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), which is 27 at defaults.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 rxd  input  1  asynchronous serial line; idles high; 8N1 frames, LSB first.
REQ-007 data_out  output  8  last received byte; holds its value until the next good frame.
REQ-008 data_valid  output  1  one-cycle pulse: data_out carries a new good byte.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit was sampled low.
REQ-010 parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 when parity is not compiled in.
REQ-011 busy  output  1  high from accepted start edge until the stop-bit decision.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized copy rxd_s and its previous value.
REQ-013 A prescaler SHALL count 0..TICK_DIV-1 and issue a one-cycle tick on its terminal count; it is held at 0 while in IDLE.
REQ-014 States: IDLE, START, DATA, PARITY (macro only), STOP; 4-bit tick counter samp_cnt, 3-bit bit counter bit_idx.
REQ-015 IDLE -> START on falling edge of rxd_s (previous 1, current 0); set busy, clear samp_cnt.
REQ-016 START: at tick with samp_cnt==OVERSAMPLE/2-1 (mid-bit), if rxd_s==1 it is a false start: -> IDLE, busy=0, no pulses; else -> DATA with samp_cnt=0 and bit_idx=0.
REQ-017 DATA: at tick with samp_cnt==OVERSAMPLE-1, shift rxd_s into bit position bit_idx; after bit_idx==7 -> PARITY (macro) or STOP; samp_cnt wraps to 0 on each sample.
REQ-018 STOP: at mid-stop sample, rxd_s==1 -> data_out<=shift register and data_valid=1 in the next cycle; rxd_s==0 -> frame_err=1 and data_out unchanged; both cases -> IDLE, busy=0.
REQ-019 Latency: data_valid rises exactly 1 clk after the mid-stop tick; the first mid-stop tick occurs 9.5 bit periods after the start edge, plus 2 sync cycles.
REQ-020 A new frame SHALL only be armed by a fresh falling edge; a line held low after a frame error (break) yields one frame_err and no further pulses until rxd returns high.
REQ-021 At most one of data_valid, frame_err and parity_err SHALL be high in any cycle.
REQ-022 Unused state encodings SHALL return to IDLE on the next clock.

Reset
REQ-023 With rst_n==0 at a clock edge: state=IDLE, data_out=8'h00, data_valid=0, frame_err=0, parity_err=0, busy=0, counters=0, and synchronizer flops=1.
REQ-024 A reset asserted mid-frame SHALL abort the frame with no pulse, and the partial byte SHALL never appear on data_out.

Configuration
REQ-025 Macro UART_RX_PARITY_EN: when defined, a PARITY state sits after DATA and samples one even-parity bit at samp_cnt==OVERSAMPLE-1.
REQ-026 With UART_RX_PARITY_EN, a parity mismatch with a good stop bit SHALL give parity_err=1, no data_valid, and data_out unchanged; a bad stop bit gives frame_err only.
REQ-027 Without UART_RX_PARITY_EN: no PARITY state, 10-bit frame, parity_err constant 0.

Verification (defaults: 1 bit = 432 clk)
REQ-028 Drive frame 0xA5 at 432 clk/bit -> one data_valid pulse, data_out=8'hA5, frame_err=0, busy low afterwards.
REQ-029 Back-to-back frames 0x00 then 0xFF with no idle gap -> two data_valid pulses, values 8'h00 then 8'hFF.
REQ-030 Low glitch of 100 clk on idle line -> no pulses, busy returns to 0 within 216+TICK_DIV clk.
REQ-031 Frame 0x3C with stop bit driven low, then line high -> frame_err pulse, data_out keeps previous value, next good frame 0x12 received correctly.
REQ-032 Assert rst_n=0 during data bit 4 of frame 0x55 -> all outputs at reset values, no data_valid; next frame 0x55 received.
REQ-033 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulse; send it with parity bit 1 -> data_valid, data_out=8'h07.
